carry_seq_ctrl: RTL and testbench

Sequencer that performs a wide add or subtract over a narrow carry-chain slice, one slice per clock. It drives the slice carry-in select with the same 2-bit encoding as the carry-init mux: 00 = 0, 01 = 1, 10 = chained. It captures operands on a start pulse, walks the slices LSB-first and returns the full-width result with carry-out and signed overflow. It sits between a requesting datapath and a single shared SLICE_W-bit adder slice built on the fabric carry chain.

---
 rtl/carry_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_carry_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/carry_seq_ctrl.sv
// Wide add/subtract sequencer that drives one shared SLICE_W-bit carry-chain
// slice per clock, LSB slice first, and returns the full-width result with
// carry-out and signed overflow.
module carry_seq_ctrl #(
  parameter int unsigned SLICE_W    = 8,
  parameter int unsigned NUM_SLICES = 4,
  localparam int unsigned W         = SLICE_W * NUM_SLICES,
  localparam int unsigned IdxW      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            op_sub,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [1:0]      carry_sel,
  output logic [IdxW-1:0] slice_idx,
  output logic [W-1:0]    result,
  output logic            carry_out,
  output logic            overflow
);

  // Carry-in select encoding, shared with the carry-init mux.
  localparam logic [1:0] CinZero  = 2'b00;
  localparam logic [1:0] CinOne   = 2'b01;
  localparam logic [1:0] CinChain = 2'b10;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SLICES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              sub_q, sub_d;
  // Partial result of the op in flight; result only sees it on completion,
  // so an aborted op leaves the last completed result untouched.
  logic [W-1:0]      shadow_q, shadow_d;
  logic              chain_q, chain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        carry_sel_q, carry_sel_d;
  logic [IdxW-1:0]   slice_idx_q, slice_idx_d;
  logic [W-1:0]      result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] b_x;
  logic               cin;
  logic [SLICE_W:0]   sum;
  logic               msb_cin;
  logic [W-1:0]       shadow_upd;

  // Slice datapath: operand select, invert for subtract, carry-in select, add.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(NUM_SLICES); i++) begin
      if (slice_idx_q == IdxW'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
    b_x = b_sl ^ {SLICE_W{sub_q}};
    case (carry_sel_q)
      CinZero:  cin = 1'b0;
      CinOne:   cin = 1'b1;
      CinChain: cin = chain_q;
      default:  cin = 1'b0;
    endcase
    sum = {1'b0, a_sl} + {1'b0, b_x} + {{SLICE_W{1'b0}}, cin};
    // Carry into the slice MSB, recovered from the MSB sum bit and its inputs.
    msb_cin = sum[SLICE_W-1] ^ a_sl[SLICE_W-1] ^ b_x[SLICE_W-1];
    shadow_upd = shadow_q;
    for (int i = 0; i < int'(NUM_SLICES); i++) begin
      if (slice_idx_q == IdxW'(i)) begin
        shadow_upd[i*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    shadow_d    = shadow_q;
    chain_d     = chain_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    carry_sel_d = carry_sel_q;
    slice_idx_d = slice_idx_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d     = StRun;
          a_d         = a;
          b_d         = b;
          sub_d       = op_sub;
          busy_d      = 1'b1;
          slice_idx_d = '0;
          carry_sel_d = op_sub ? CinOne : CinZero;
        end
      end
      StRun: begin
        if (abort) begin
          state_d     = StIdle;
          busy_d      = 1'b0;
          carry_sel_d = CinZero;
          slice_idx_d = '0;
        end else begin
          shadow_d = shadow_upd;
          chain_d  = sum[SLICE_W];
          if (slice_idx_q == LastIdx) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            carry_sel_d = CinZero;
            slice_idx_d = '0;
            result_d    = shadow_upd;
            carry_out_d = sum[SLICE_W];
            overflow_d  = msb_cin ^ sum[SLICE_W];
          end else begin
            slice_idx_d = slice_idx_q + 1'b1;
            carry_sel_d = CinChain;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      shadow_q    <= '0;
      chain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_sel_q <= CinZero;
      slice_idx_q <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      shadow_q    <= shadow_d;
      chain_q     <= chain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      carry_sel_q <= carry_sel_d;
      slice_idx_q <= slice_idx_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign carry_sel = carry_sel_q;
  assign slice_idx = slice_idx_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_carry_seq_ctrl.sv
// Directed bench for carry_seq_ctrl with SLICE_W=8, NUM_SLICES=4.
module tb_carry_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        op_sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [1:0]  carry_sel;
  logic [1:0]  slice_idx;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  carry_seq_ctrl #(
    .SLICE_W   (8),
    .NUM_SLICES(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .carry_sel(carry_sel),
    .slice_idx(slice_idx),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait for done; returns cycles from start edge to done
  // (0 on timeout) and the carry_sel seen in the four slice cycles.
  task automatic do_op(input logic sub, input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output logic [7:0] seq);
    a = av;
    b = bv;
    op_sub = sub;
    start = 1'b1;
    step();
    start = 1'b0;
    seq = {carry_sel, 6'b0};
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done) begin
        lat = c;
        break;
      end
      if (c < 4) seq[7-2*c -: 2] = carry_sel;
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] res, input logic co,
                            input logic ov);
    check_eq({tag, "_result"}, result, res);
    check_eq({tag, "_carry_out"}, carry_out, co);
    check_eq({tag, "_overflow"}, overflow, ov);
  endtask

  initial begin
    int         lat;
    logic [7:0] seq;
    int         done_cnt;

    #2 rst = 1'b1;
    #10;
    check_eq("rst_outputs", {busy, done, carry_sel, slice_idx, result, carry_out, overflow},
             64'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();

    // Add with full carry ripple.
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat, seq);
    check_eq("add_ff_latency", lat, 4);
    check_eq("add_ff_carry_sel", seq, 8'b00_10_10_10);
    check_eq("add_ff_done", done, 1'b1);
    check_outs("add_ff", 32'h0000_0000, 1'b1, 1'b0);
    step();
    check_eq("done_one_cycle", {done, busy}, 2'b00);

    // Subtract with full borrow.
    do_op(1'b1, 32'h0000_0000, 32'h0000_0001, lat, seq);
    check_eq("sub_0_latency", lat, 4);
    check_eq("sub_0_carry_sel", seq, 8'b01_10_10_10);
    check_outs("sub_0", 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Signed overflow both directions.
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat, seq);
    check_outs("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat, seq);
    check_outs("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

    // start ignored while running; start in done cycle launches the next op.
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    op_sub = 1'b0;
    start = 1'b1;
    step();
    check_eq("b2b_busy", busy, 1'b1);
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    op_sub = 1'b1;
    step();
    step();
    step();
    start = 1'b0;
    step();
    check_eq("b2b_first_done", done, 1'b1);
    check_outs("b2b_first", 32'h2345_6789, 1'b0, 1'b0);
    a = 32'h0000_0010;
    b = 32'h0000_0001;
    op_sub = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("b2b_second_busy", busy, 1'b1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done) begin
        lat = c;
        break;
      end
    end
    check_eq("b2b_second_latency", lat, 4);
    check_outs("b2b_second", 32'h0000_000F, 1'b1, 1'b0);

    // abort at slice 2: no done, result keeps prior value.
    a = 32'h0101_0101;
    b = 32'h0101_0101;
    op_sub = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("abort_idx", slice_idx, 2'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_state", {busy, done, carry_sel, slice_idx}, 6'b0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done) done_cnt++;
    end
    check_eq("abort_no_done", done_cnt, 0);
    check_outs("abort_keep", 32'h0000_000F, 1'b1, 1'b0);

    // abort together with start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_start_idle", busy, 1'b0);
    step();
    check_eq("abort_start_idle2", busy, 1'b0);

    // abort on the last slice cycle.
    a = 32'h0000_0002;
    b = 32'h0000_0002;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check_eq("abort_last_idx", slice_idx, 2'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_last", {busy, done}, 2'b00);
    check_outs("abort_last_keep", 32'h0000_000F, 1'b1, 1'b0);

    // Asynchronous reset mid-op, between edges.
    a = 32'h0000_00FF;
    b = 32'h0000_0001;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_op", {busy, done, carry_sel, slice_idx, result, carry_out, overflow},
             64'h0);
    rst = 1'b0;
    step();
    do_op(1'b0, 32'h0000_0005, 32'h0000_0003, lat, seq);
    check_eq("post_rst_latency", lat, 4);
    check_outs("post_rst", 32'h0000_0008, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
